qspi_burst_ctrl: RTL

Sequencer directly upstream of the QSPI PSRAM master. It accepts word-burst commands on a valid/ready interface and buffers write data and read data in two FIFOs. It splits each burst into chip-select segments that respect the PSRAM page and tCEM limits, and drives the master's level-held `wr_req`/`rd_req`, `addr` and `data_in`. The master cannot stall mid-transaction, so every segment is started only when its full data, or full read space, is guaranteed.

---
 rtl/qspi_burst_ctrl_pkg.sv | 38 +++
 rtl/qspi_sync_fifo.sv | 64 ++++++
 rtl/qspi_burst_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : qspi_burst_ctrl_pkg
// Brief    : FSM encoding and segment sizing shared by the QSPI burst sequencer.
// Revision : 1.0
// ============================================================================
package qspi_burst_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_WAIT   = 3'd1;
    localparam state_t S_ISSUE  = 3'd2;
    localparam state_t S_STREAM = 3'd3;
    localparam state_t S_TAIL   = 3'd4;
    localparam state_t S_GAP    = 3'd5;

    localparam logic [1:0] C_TAIL_LAST = 2'd3;
    localparam logic [1:0] C_GAP_LAST  = 2'd1;

    // Words in the next chip-select: bounded by what is left, tCEM and the page end.
    function automatic logic [31:0] seg_words(
        input logic [31:0] addr,
        input logic [31:0] remaining,
        input logic [31:0] max_burst,
        input logic [31:0] page_bytes
    );
        logic [31:0] to_page;
        logic [31:0] s;
        to_page = (page_bytes - (addr & (page_bytes - 32'd1))) >> 1;
        s = remaining;
        if (max_burst < s) s = max_burst;
        if (to_page < s) s = to_page;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qspi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qspi_sync_fifo
// Brief    : Single-clock FIFO with first-word-fall-through read, count and flags.
// Revision : 1.0
// ============================================================================
module qspi_sync_fifo #(
    parameter int DSZ        = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          push_i,
    input  logic [DSZ-1:0]                push_data_i,
    input  logic                          pop_i,
    output logic [DSZ-1:0]                pop_data_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);
    localparam logic [AW:0]   C_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   C_CNT_FULL = (AW+1)'(FIFO_DEPTH);

    logic [DSZ-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wptr_q;
    logic [AW-1:0]  rptr_q;
    logic [AW:0]    cnt_q;
    logic           w_push;
    logic           w_pop;

    assign w_pop  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + C_PTR_ONE;
            if (w_pop)  rptr_q <= rptr_q + C_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + C_CNT_ONE;
                2'b01:   cnt_q <= cnt_q - C_CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign pop_data_o = mem_q[rptr_q];
    assign count_o    = cnt_q;
    assign full_o     = (cnt_q == C_CNT_FULL);
    assign empty_o    = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/qspi_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qspi_burst_ctrl
// Brief    : Splits word bursts into page/tCEM-safe segments for the QSPI PSRAM master.
// Revision : 1.0
// ============================================================================
module qspi_burst_ctrl
    import qspi_burst_ctrl_pkg::*;
#(
    parameter int ASZ        = 22,
    parameter int DSZ        = 16,
    parameter int LEN_W      = 8,
    parameter int PAGE_BYTES = 1024,
    parameter int MAX_BURST  = 32,
    parameter int FIFO_DEPTH = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [ASZ-1:0]   cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [DSZ-1:0]   wdata,
    input  logic             wdata_valid,
    output logic             wdata_ready,
    output logic [DSZ-1:0]   rdata,
    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic             busy,
    output logic [ASZ-1:0]   m_addr,
    output logic [DSZ-1:0]   m_data_in,
    input  logic [DSZ-1:0]   m_data_out,
    input  logic             m_wr_valid,
    input  logic             m_rd_valid,
    output logic             m_wr_req,
    output logic             m_rd_req
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W:0] C_ONE = (LEN_W+1)'(1);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [ASZ-1:0]   addr_q, addr_d;
    logic [LEN_W:0]   rem_q, rem_d;
    logic [LEN_W:0]   seg_q, seg_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic [1:0]       tmr_q, tmr_d;
    logic [ASZ-1:0]   maddr_q, maddr_d;
    logic [DSZ-1:0]   mdata_q, mdata_d;
    logic             wreq_q, wreq_d;
    logic             rreq_q, rreq_d;
    logic             run_q;

    logic [LEN_W:0]   w_seg;
    logic             w_space_ok;
    logic             w_last;
    logic             w_wpop;
    logic             w_rpush;
    logic [DSZ-1:0]   w_whead;
    logic [CW-1:0]    w_wcnt;
    logic [CW-1:0]    w_rcnt;
    logic             w_wfull, w_wempty, w_rfull, w_rempty;

    assign w_seg = (LEN_W+1)'(seg_words(32'(addr_q), 32'(rem_q),
                                        32'(MAX_BURST), 32'(PAGE_BYTES)));
    // The master cannot stall, so a segment starts only once all of it is covered.
    assign w_space_ok = dir_q ? (32'(w_wcnt) >= 32'(w_seg))
                              : ((32'(FIFO_DEPTH) - 32'(w_rcnt)) >= 32'(w_seg));
    assign w_last = ((cnt_q + C_ONE) == seg_q);

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        wreq_d  = wreq_q;
        rreq_d  = rreq_q;
        w_wpop  = 1'b0;
        w_rpush = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    dir_d   = cmd_write;
                    addr_d  = cmd_addr & ~ASZ'(1);
                    rem_d   = {1'b0, cmd_len} + C_ONE;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_space_ok) begin
                    seg_d   = w_seg;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                maddr_d = addr_q;
                cnt_d   = '0;
                if (dir_q) begin
                    w_wpop  = 1'b1;
                    mdata_d = w_whead;
                    wreq_d  = 1'b1;
                end else begin
                    rreq_d  = 1'b1;
                end
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (dir_q) begin
                    if (m_wr_valid) begin
                        cnt_d = cnt_q + C_ONE;
                        if (w_last) begin
                            tmr_d   = '0;
                            state_d = S_TAIL;
                        end else begin
                            w_wpop  = 1'b1;
                            mdata_d = w_whead;
                        end
                    end
                end else if (m_rd_valid) begin
                    w_rpush = 1'b1;
                    cnt_d   = cnt_q + C_ONE;
                    if (w_last) begin
                        rreq_d  = 1'b0;
                        tmr_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_TAIL: begin
                // Last word is still shifting out of the master.
                tmr_d = tmr_q + 2'd1;
                if (tmr_q == C_TAIL_LAST) begin
                    wreq_d  = 1'b0;
                    tmr_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                tmr_d = tmr_q + 2'd1;
                if (tmr_q == C_GAP_LAST) begin
                    rem_d   = rem_q - seg_q;
                    addr_d  = addr_q + ASZ'({seg_q, 1'b0});
                    tmr_d   = '0;
                    state_d = (rem_q == seg_q) ? S_IDLE : S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
            addr_q  <= '0;
            rem_q   <= '0;
            seg_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            maddr_q <= '0;
            mdata_q <= '0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            wreq_q  <= wreq_d;
            rreq_q  <= rreq_d;
            run_q   <= 1'b1;
        end
    end

    qspi_sync_fifo #(.DSZ(DSZ), .FIFO_DEPTH(FIFO_DEPTH)) u_wfifo (
        .clk         (clk),
        .nreset      (nreset),
        .push_i      (wdata_valid & wdata_ready),
        .push_data_i (wdata),
        .pop_i       (w_wpop & ~w_wempty),
        .pop_data_o  (w_whead),
        .count_o     (w_wcnt),
        .full_o      (w_wfull),
        .empty_o     (w_wempty)
    );

    qspi_sync_fifo #(.DSZ(DSZ), .FIFO_DEPTH(FIFO_DEPTH)) u_rfifo (
        .clk         (clk),
        .nreset      (nreset),
        .push_i      (w_rpush & ~w_rfull),
        .push_data_i (m_data_out),
        .pop_i       (rdata_ready),
        .pop_data_o  (rdata),
        .count_o     (w_rcnt),
        .full_o      (w_rfull),
        .empty_o     (w_rempty)
    );

    assign cmd_ready   = run_q & (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign wdata_ready = run_q & ~w_wfull;
    assign rdata_valid = ~w_rempty;
    assign m_addr      = maddr_q;
    assign m_data_in   = mdata_q;
    assign m_wr_req    = wreq_q;
    assign m_rd_req    = rreq_q;

endmodule
`default_nettype wire
